// File: rtl/key_search_pkg.sv
// key_search_pkg
//   Shared types and constants for the RC4 key-search controller slice.
//   ks_state_t : controller FSM states
//   KEY_W      : default secret-key width
//   KEY_LIMIT  : last key of the total search space
//   idx_w()    : width of a core index (never below 1 bit)
package key_search_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        FOUND,
        EXHAUSTED
    } ks_state_t;

    localparam int KEY_W = 24;
    localparam logic [KEY_W-1:0] KEY_LIMIT = 24'h3FFFFF;

    // A single core still needs a 1-bit index port.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lowest_set_index.sv
// lowest_set_index
//   Priority encoder: reports the position of the lowest set bit of vec.
//   Ports:
//     vec  in   N           request vector
//     idx  out  idx_w(N)    index of lowest set bit (0 when vec is empty)
//     any  out  1           at least one bit of vec is set
module lowest_set_index
    import key_search_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = idx_w(N)
) (
    input  logic [N-1:0]  vec,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Scan from the top down so the lowest set bit is the last to write idx.
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) idx = IW'(i);
        end
    end

    assign any = |vec;

endmodule

// File: rtl/key_search_controller.sv
// key_search_controller
//   Monitors NUM_CORES parallel RC4 decryption cores, latches the first
//   successful key, halts every core once a key is found or all ranges are
//   exhausted, and counts the clocks spent searching.
//   Ports:
//     clk             in   1                 system clock
//     reset           in   1                 asynchronous active-high reset
//     start           in   1                 begin search (honoured in IDLE only)
//     core_success    in   NUM_CORES         per-core valid-message flag
//     core_exhausted  in   NUM_CORES         per-core end-of-range flag
//     core_key        in   NUM_CORES*KEY_W   core i key at [i*KEY_W +: KEY_W]
//     stop_all        out  1                 halt to every core's outer_finish
//     busy            out  1                 searching
//     found           out  1                 sticky success
//     exhausted       out  1                 sticky no-key-found
//     found_key       out  KEY_W             winning key
//     found_core      out  idx_w(NUM_CORES)  winning core index
//     search_cycles   out  CNT_W             clocks spent in SEARCH, saturating
//   Every output is a register or a decode of the state register; no input
//   reaches an output combinationally.
module key_search_controller
    import key_search_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int KEY_W     = 24,
    parameter int CNT_W     = 32
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [NUM_CORES-1:0]            core_success,
    input  logic [NUM_CORES-1:0]            core_exhausted,
    input  logic [NUM_CORES*KEY_W-1:0]      core_key,
    output logic                            stop_all,
    output logic                            busy,
    output logic                            found,
    output logic                            exhausted,
    output logic [KEY_W-1:0]                found_key,
    output logic [idx_w(NUM_CORES)-1:0]     found_core,
    output logic [CNT_W-1:0]                search_cycles
);

    localparam int IDX_W = idx_w(NUM_CORES);

    ks_state_t            state_q, state_d;
    logic [NUM_CORES-1:0] done_mask_q, done_mask_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [KEY_W-1:0]     key_q, key_d;
    logic [IDX_W-1:0]     core_q, core_d;

    logic [IDX_W-1:0]     win_idx;
    logic                 win_any;
    logic [KEY_W-1:0]     win_key;
    logic [NUM_CORES-1:0] done_all;

    lowest_set_index #(
        .N (NUM_CORES)
    ) u_arb (
        .vec (core_success),
        .idx (win_idx),
        .any (win_any)
    );

    assign win_key  = core_key[int'(win_idx)*KEY_W +: KEY_W];
    // Include this cycle's pulses so the last core to finish ends the search
    // on the same edge its pulse is sampled.
    assign done_all = done_mask_q | core_exhausted;

    always_comb begin
        state_d     = state_q;
        done_mask_d = done_mask_q;
        cnt_d       = cnt_q;
        key_d       = key_q;
        core_d      = core_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = SEARCH;
                    done_mask_d = '0;
                    cnt_d       = '0;
                end
            end
            SEARCH: begin
                if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
                done_mask_d = done_all;
                // Success outranks exhaustion, even from the same core.
                if (win_any) begin
                    state_d = FOUND;
                    key_d   = win_key;
                    core_d  = win_idx;
                end else if (&done_all) begin
                    state_d = EXHAUSTED;
                end
            end
            FOUND:     ;
            EXHAUSTED: ;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            done_mask_q <= '0;
            cnt_q       <= '0;
            key_q       <= '0;
            core_q      <= '0;
        end else begin
            state_q     <= state_d;
            done_mask_q <= done_mask_d;
            cnt_q       <= cnt_d;
            key_q       <= key_d;
            core_q      <= core_d;
        end
    end

    assign busy          = (state_q == SEARCH);
    assign found         = (state_q == FOUND);
    assign exhausted     = (state_q == EXHAUSTED);
    assign stop_all      = found | exhausted;
    assign found_key     = key_q;
    assign found_core    = core_q;
    assign search_cycles = cnt_q;

endmodule

// File: tb/tb_key_search_controller.sv
module tb_key_search_controller;

    localparam int NC = 4;
    localparam int KW = 24;
    localparam int CW = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic [NC-1:0]   core_success = '0;
    logic [NC-1:0]   core_exhausted = '0;
    logic [NC*KW-1:0] core_key = '0;
    logic            stop_all, busy, found, exhausted;
    logic [KW-1:0]   found_key;
    logic [1:0]      found_core;
    logic [CW-1:0]   search_cycles;

    key_search_controller #(.NUM_CORES(NC), .KEY_W(KW), .CNT_W(CW)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .core_success   (core_success),
        .core_exhausted (core_exhausted),
        .core_key       (core_key),
        .stop_all       (stop_all),
        .busy           (busy),
        .found          (found),
        .exhausted      (exhausted),
        .found_key      (found_key),
        .found_core     (found_core),
        .search_cycles  (search_cycles)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [CW-1:0] sat(input int n);
        return (n >= (1 << CW) - 1) ? {CW{1'b1}} : CW'(n);
    endfunction

    // Per-cycle stimulus schedule, index 0 = first cycle spent searching.
    logic [NC-1:0] s_succ [64];
    logic [NC-1:0] s_exh  [64];
    bit            s_start[64];
    logic [KW-1:0] s_key  [64][NC];
    int            s_len;

    typedef struct {
        bit            f;
        bit            e;
        logic [KW-1:0] key;
        logic [1:0]    core;
        logic [CW-1:0] cy;
        int            at;
    } exp_t;

    exp_t q[$];
    exp_t last;
    bit   last_term;

    task automatic clr_sched(input int len);
        s_len = len;
        for (int c = 0; c < 64; c++) begin
            s_succ[c] = '0;
            s_exh[c] = '0;
            s_start[c] = 1'b0;
            for (int k = 0; k < NC; k++) s_key[c][k] = KW'($urandom());
        end
    endtask

    // Reference: first cycle with any success wins (lowest core); otherwise
    // the first cycle by which every core has reported done.
    task automatic predict(input int base);
        logic [NC-1:0] seen;
        exp_t x;
        int w;
        seen = '0;
        last_term = 1'b0;
        for (int c = 0; c < s_len; c++) begin
            if (s_succ[c] != 0) begin
                w = 0;
                while (!s_succ[c][w]) w++;
                x.f = 1'b1; x.e = 1'b0; x.key = s_key[c][w]; x.core = w[1:0];
                x.cy = sat(c + 1); x.at = base + 2 + c;
                q.push_back(x); last = x; last_term = 1'b1;
                return;
            end
            seen = seen | s_exh[c];
            if (seen == {NC{1'b1}}) begin
                x.f = 1'b0; x.e = 1'b1; x.key = '0; x.core = '0;
                x.cy = sat(c + 1); x.at = base + 2 + c;
                q.push_back(x); last = x; last_term = 1'b1;
                return;
            end
        end
    endtask

    task automatic clear_inputs();
        start = 1'b0;
        core_success = '0;
        core_exhausted = '0;
    endtask

    task automatic run();
        int base;
        @(posedge clk); #1;
        start = 1'b1;
        base = cyc;
        predict(base);
        for (int c = 0; c < s_len; c++) begin
            @(posedge clk); #1;
            start = s_start[c];
            core_success = s_succ[c];
            core_exhausted = s_exh[c];
            for (int k = 0; k < NC; k++) core_key[k*KW +: KW] = s_key[c][k];
        end
        @(posedge clk); #1;
        clear_inputs();
        if (!last_term) begin
            check("busy_open", busy, 1);
            check("stop_open", stop_all, 0);
            check("found_open", found, 0);
            check("exh_open", exhausted, 0);
            check("cycles_open", search_cycles, sat(s_len));
        end else begin
            // Terminal states must ignore everything until reset.
            for (int i = 0; i < 4; i++) begin
                @(posedge clk); #1;
                start = 1'($urandom());
                core_success = NC'($urandom());
                core_exhausted = NC'($urandom());
                core_key = {NC{KW'($urandom())}};
            end
            @(posedge clk); #1;
            clear_inputs();
            check("event_seen", q.size(), 0);
            q.delete();
            check("hold_found", found, last.f);
            check("hold_exh", exhausted, last.e);
            check("hold_stop", stop_all, 1);
            check("hold_busy", busy, 0);
            check("hold_key", found_key, last.key);
            check("hold_core", found_core, last.core);
            check("hold_cycles", search_cycles, last.cy);
        end
        // Reset between edges must clear outputs without a clock.
        #2;
        reset = 1'b1;
        #1;
        check("ar_stop", stop_all, 0);
        check("ar_busy", busy, 0);
        check("ar_cycles", search_cycles, 0);
        check("ar_found", found, 0);
        check("ar_exh", exhausted, 0);
        check("ar_key", found_key, 0);
        check("ar_core", found_core, 0);
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Monitor: every rising stop_all must match the oldest expectation.
    logic prev_stop = 1'b0;
    always @(negedge clk) begin
        exp_t x;
        if (stop_all && !prev_stop) begin
            if (q.size() == 0) begin
                check("pending_expect", q.size(), 1);
            end else begin
                x = q.pop_front();
                check("mon_found", found, x.f);
                check("mon_exh", exhausted, x.e);
                check("mon_busy", busy, 0);
                check("mon_key", found_key, x.key);
                check("mon_core", found_core, x.core);
                check("mon_cycles", search_cycles, x.cy);
                check("mon_latency", cyc, x.at);
            end
        end
        prev_stop <= stop_all;
    end

    initial begin
        // Reset state and IDLE ignoring core inputs.
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_stop", stop_all, 0);
        check("rst_busy", busy, 0);
        check("rst_found", found, 0);
        check("rst_exh", exhausted, 0);
        check("rst_key", found_key, 0);
        check("rst_core", found_core, 0);
        check("rst_cycles", search_cycles, 0);
        core_success = 4'b0010;
        core_exhausted = 4'b1111;
        repeat (3) @(posedge clk);
        #1;
        check("idle_found", found, 0);
        check("idle_exh", exhausted, 0);
        check("idle_busy", busy, 0);
        clear_inputs();

        // Single success after 10 cycles, with a start pulse mid-search.
        clr_sched(11);
        s_succ[10] = 4'b0100;
        s_key[10][2] = 24'h0A3F1C;
        s_start[5] = 1'b1;
        run();

        // Two simultaneous successes resolve to the lower core.
        clr_sched(4);
        s_succ[3] = 4'b1010;
        s_key[3][1] = 24'h111111;
        s_key[3][3] = 24'h222222;
        run();

        // Staggered exhaustion 0,2,1,3.
        clr_sched(10);
        s_exh[2] = 4'b0001;
        s_exh[4] = 4'b0100;
        s_exh[5] = 4'b0010;
        s_exh[8] = 4'b1000;
        run();

        // Success beats the exhaustion that would complete the mask.
        clr_sched(6);
        s_exh[1] = 4'b0001;
        s_exh[2] = 4'b0010;
        s_exh[3] = 4'b0100;
        s_exh[5] = 4'b1000;
        s_succ[5] = 4'b0001;
        s_key[5][0] = 24'h00ABCD;
        run();

        // A core reporting success and exhaustion together counts as success.
        clr_sched(3);
        s_exh[2] = 4'b1111;
        s_succ[2] = 4'b0100;
        run();

        // Long search saturates the counter; start mid-search is ignored.
        clr_sched(20);
        s_start[7] = 1'b1;
        run();

        // Randomized searches.
        for (int r = 0; r < 40; r++) begin
            clr_sched($urandom_range(5, 25));
            for (int c = 0; c < s_len; c++) begin
                if ($urandom_range(0, 19) == 0) s_succ[c] = NC'($urandom());
                if ($urandom_range(0, 2) == 0) s_exh[c] = NC'(1 << $urandom_range(0, NC - 1));
                if ($urandom_range(0, 9) == 0) s_exh[c] = s_exh[c] | NC'($urandom());
                if ($urandom_range(0, 15) == 0) s_start[c] = 1'b1;
            end
            run();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
